// File: rtl/ppu_pkg.sv
// Shared PPU definitions: OAM DMA register address, transfer size and FSM state encoding.
package ppu_pkg;

   localparam logic [15:0] OAM_DMA_REG = 16'h4014;
   localparam int unsigned OAM_BYTES   = 256;

   typedef enum logic [2:0] {
      DmaIdle  = 3'd0,
      DmaHalt  = 3'd1,
      DmaAlign = 3'd2,
      DmaRead  = 3'd3,
      DmaWrite = 3'd4
   } oam_dma_state_t;

endpackage

// File: rtl/oam_dma_ctrl.sv
// OAM DMA ($4014) writer: halts the CPU, reads one 256-byte page over the CPU bus and streams it
// into primary OAM starting at the latched OAMADDR, wrapping modulo 256.
// Optional feature macro: OAM_DMA_ODD_ALIGN_EN (adds the odd-cycle ALIGN state).
// OAM_BYTES comes from ppu_pkg; ADDR_W must stay 16 since the address is {page, idx}.
module oam_dma_ctrl
   import ppu_pkg::*;
#(
   parameter int unsigned ADDR_W = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cpu_ce,
   input  logic              cpu_odd,
   input  logic              reg_we,
   input  logic [7:0]        reg_data,
   input  logic [7:0]        oam_start,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [7:0]        mem_data_in,
   output logic              cpu_halt,
   output logic              oam_dma,
   output logic [7:0]        oam_addr,
   output logic [7:0]        oam_data,
   output logic              dma_done
);

   localparam logic [7:0] LAST_IDX = 8'(OAM_BYTES - 1);

   oam_dma_state_t state_q, state_d;
   logic [7:0]     page_q, page_d;
   logic [7:0]     base_q, base_d;
   logic [7:0]     idx_q, idx_d;
   logic           last_byte;

   assign last_byte = (idx_q == LAST_IDX);

`ifndef OAM_DMA_ODD_ALIGN_EN
   // Without odd alignment every transfer has the same length.
   logic unused_cpu_odd;
   assign unused_cpu_odd = cpu_odd;
`endif

   // Next-state logic: nothing moves unless this clk carries a CPU cycle.
   always_comb begin
      state_d = state_q;
      page_d  = page_q;
      base_d  = base_q;
      idx_d   = idx_q;
      if (cpu_ce) begin
         unique case (state_q)
            DmaIdle: begin
               if (reg_we) begin
                  page_d  = reg_data;
                  base_d  = oam_start;
                  idx_d   = 8'h00;
                  state_d = DmaHalt;
               end
            end
            DmaHalt: begin
`ifdef OAM_DMA_ODD_ALIGN_EN
               state_d = cpu_odd ? DmaAlign : DmaRead;
`else
               state_d = DmaRead;
`endif
            end
            DmaAlign: state_d = DmaRead;
            DmaRead:  state_d = DmaWrite;
            DmaWrite: begin
               if (last_byte) begin
                  state_d = DmaIdle;
               end else begin
                  idx_d   = idx_q + 8'h01;
                  state_d = DmaRead;
               end
            end
            default: state_d = DmaIdle;
         endcase
      end
   end

   // State and transfer registers; async reset abandons any transfer in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= DmaIdle;
         page_q  <= 8'h00;
         base_q  <= 8'h00;
         idx_q   <= 8'h00;
      end else begin
         state_q <= state_d;
         page_q  <= page_d;
         base_q  <= base_d;
         idx_q   <= idx_d;
      end
   end

   // Outputs decoded from registered state; the OAM strobe is gated by cpu_ce so each byte
   // is written exactly once even when a WRITE state spans several clks.
   always_comb begin
      cpu_halt = (state_q != DmaIdle);
      mem_rd   = (state_q == DmaRead);
      mem_addr = '0;
      oam_dma  = 1'b0;
      oam_addr = 8'h00;
      oam_data = 8'h00;
      dma_done = 1'b0;
      if (state_q == DmaRead || state_q == DmaWrite) begin
         mem_addr = ADDR_W'({page_q, idx_q});
      end
      if (state_q == DmaWrite) begin
         oam_addr = base_q + idx_q;
         oam_data = mem_data_in;
         oam_dma  = cpu_ce;
         dma_done = cpu_ce & last_byte;
      end
   end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl: synchronous RAM model, OAM capture, per-scenario checks.
module tb_oam_dma_ctrl;

   logic        clk;
   logic        reset_n;
   logic        cpu_ce;
   logic        cpu_odd;
   logic        reg_we;
   logic [7:0]  reg_data;
   logic [7:0]  oam_start;
   logic [15:0] mem_addr;
   logic        mem_rd;
   logic [7:0]  mem_data_in;
   logic        cpu_halt;
   logic        oam_dma;
   logic [7:0]  oam_addr;
   logic [7:0]  oam_data;
   logic        dma_done;

   oam_dma_ctrl dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .cpu_ce      (cpu_ce),
      .cpu_odd     (cpu_odd),
      .reg_we      (reg_we),
      .reg_data    (reg_data),
      .oam_start   (oam_start),
      .mem_addr    (mem_addr),
      .mem_rd      (mem_rd),
      .mem_data_in (mem_data_in),
      .cpu_halt    (cpu_halt),
      .oam_dma     (oam_dma),
      .oam_addr    (oam_addr),
      .oam_data    (oam_data),
      .dma_done    (dma_done)
   );

   int err = 0;
   int chk = 0;

   // Test pattern: page 2 holds i^5A, other pages differ by (page-2).
   function automatic logic [7:0] ram_val(input logic [15:0] a);
      return a[7:0] ^ 8'h5A ^ (a[15:8] - 8'h02);
   endfunction

   logic [7:0] ram [65536];
   logic [7:0] mem_q;
   initial for (int a = 0; a < 65536; a++) ram[a] = ram_val(16'(a));
   always @(posedge clk) if (mem_rd) mem_q <= ram[mem_addr];
   assign mem_data_in = mem_q;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // cpu_ce generator: every clk (mode 0) or one clk in three (mode 1).
   int ce_mode = 0;
   initial begin
      int ce_div;
      ce_div = 0;
      cpu_ce = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (ce_mode == 0) begin
            cpu_ce = 1'b1;
         end else begin
            ce_div = (ce_div == 2) ? 0 : ce_div + 1;
            cpu_ce = (ce_div == 0);
         end
      end
   end

   // Observer: sampled mid-cycle, records OAM writes and halt/done activity.
   logic       clr = 1'b0;
   logic [7:0] oam_mem [256];
   logic [7:0] wr_addr [512];
   logic [7:0] wr_data [512];
   int write_cnt, halt_clks, halt_ce, done_cnt, ce_bad;
   logic [7:0] done_addr;
   always @(negedge clk) begin
      if (clr) begin
         write_cnt <= 0;
         halt_clks <= 0;
         halt_ce   <= 0;
         done_cnt  <= 0;
         ce_bad    <= 0;
         done_addr <= 8'h00;
         for (int i = 0; i < 256; i++) oam_mem[i] <= 8'hEE;
      end else begin
         if (cpu_halt) halt_clks <= halt_clks + 1;
         if (cpu_halt && cpu_ce) halt_ce <= halt_ce + 1;
         if (oam_dma) begin
            if (!cpu_ce) ce_bad <= ce_bad + 1;
            if (write_cnt < 512) begin
               wr_addr[write_cnt] <= oam_addr;
               wr_data[write_cnt] <= oam_data;
            end
            oam_mem[oam_addr] <= oam_data;
            write_cnt <= write_cnt + 1;
         end
         if (dma_done) begin
            done_cnt  <= done_cnt + 1;
            done_addr <= oam_addr;
         end
      end
   end

   task automatic start_dma(input logic [7:0] page, input logic [7:0] start);
      @(posedge clk);
      #2;
      reg_data  = page;
      oam_start = start;
      clr       = 1'b1;
      @(negedge clk);
      #1;
      clr = 1'b0;
      @(posedge clk);
      #2;
      while (!cpu_ce) begin
         @(posedge clk);
         #2;
      end
      reg_we = 1'b1;
      @(posedge clk);
      #2;
      reg_we = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < budget; n++) begin
         @(posedge clk);
         if (done_cnt > 0 && !cpu_halt) begin
            ok = 1'b1;
            break;
         end
      end
      repeat (3) @(posedge clk);
   endtask

   task automatic wait_writes(input int target, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 5000; n++) begin
         @(posedge clk);
         if (write_cnt >= target) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      reset_n   = 1'b0;
      reg_we    = 1'b0;
      reg_data  = 8'h00;
      oam_start = 8'h00;
      cpu_odd   = 1'b0;
      #23;
      chk++; if (cpu_halt !== 1'b0) begin err++; $display("FAIL reset_halt got %b want 0", cpu_halt); end
      chk++; if (mem_rd !== 1'b0) begin err++; $display("FAIL reset_mem_rd got %b want 0", mem_rd); end
      chk++; if (mem_addr !== 16'h0000) begin err++; $display("FAIL reset_mem_addr got %h want 0000", mem_addr); end
      chk++; if (oam_dma !== 1'b0) begin err++; $display("FAIL reset_oam_dma got %b want 0", oam_dma); end
      chk++; if (oam_addr !== 8'h00) begin err++; $display("FAIL reset_oam_addr got %h want 00", oam_addr); end
      chk++; if (oam_data !== 8'h00) begin err++; $display("FAIL reset_oam_data got %h want 00", oam_data); end
      chk++; if (dma_done !== 1'b0) begin err++; $display("FAIL reset_done got %b want 0", dma_done); end
      @(posedge clk);
      #2;
      reset_n = 1'b1;
   endtask

   task automatic test_basic;
      bit ok;
      int bad;
      start_dma(8'h02, 8'h00);
      wait_done(3000, ok);
      chk++; if (ok !== 1'b1) begin err++; $display("FAIL basic_timeout got %b want 1", ok); end
      chk++; if (halt_clks !== 513) begin err++; $display("FAIL basic_halt got %0d want 513", halt_clks); end
      chk++; if (write_cnt !== 256) begin err++; $display("FAIL basic_writes got %0d want 256", write_cnt); end
      chk++; if (done_cnt !== 1) begin err++; $display("FAIL basic_done got %0d want 1", done_cnt); end
      chk++; if (done_addr !== 8'hFF) begin err++; $display("FAIL basic_done_addr got %h want ff", done_addr); end
      bad = 0;
      for (int i = 0; i < 256; i++) if (oam_mem[i] !== (8'(i) ^ 8'h5A)) bad++;
      chk++; if (bad !== 0) begin err++; $display("FAIL basic_oam bad_bytes got %0d want 0", bad); end
      chk++; if (mem_addr !== 16'h0000 || cpu_halt !== 1'b0) begin
         err++; $display("FAIL basic_idle got addr=%h halt=%b want 0000/0", mem_addr, cpu_halt);
      end
   endtask

   task automatic test_odd;
      bit ok;
      int bad;
      int exp_halt;
`ifdef OAM_DMA_ODD_ALIGN_EN
      exp_halt = 514;
`else
      exp_halt = 513;
`endif
      cpu_odd = 1'b1;
      start_dma(8'h02, 8'h00);
      wait_done(3000, ok);
      cpu_odd = 1'b0;
      chk++; if (ok !== 1'b1) begin err++; $display("FAIL odd_timeout got %b want 1", ok); end
      chk++; if (halt_clks !== exp_halt) begin err++; $display("FAIL odd_halt got %0d want %0d", halt_clks, exp_halt); end
      chk++; if (write_cnt !== 256) begin err++; $display("FAIL odd_writes got %0d want 256", write_cnt); end
      bad = 0;
      for (int i = 0; i < 256; i++) if (oam_mem[i] !== (8'(i) ^ 8'h5A)) bad++;
      chk++; if (bad !== 0) begin err++; $display("FAIL odd_oam bad_bytes got %0d want 0", bad); end
   endtask

   task automatic test_wrap;
      bit ok;
      int bad;
      start_dma(8'h03, 8'hF0);
      repeat (20) @(posedge clk);
      #2;
      oam_start = 8'h33;
      wait_done(3000, ok);
      chk++; if (ok !== 1'b1) begin err++; $display("FAIL wrap_timeout got %b want 1", ok); end
      chk++; if (wr_addr[0] !== 8'hF0 || wr_data[0] !== 8'h5B) begin
         err++; $display("FAIL wrap_first got %h/%h want f0/5b", wr_addr[0], wr_data[0]);
      end
      chk++; if (wr_addr[16] !== 8'h00 || wr_data[16] !== 8'h4B) begin
         err++; $display("FAIL wrap_zero got %h/%h want 00/4b", wr_addr[16], wr_data[16]);
      end
      chk++; if (wr_addr[255] !== 8'hEF || wr_data[255] !== 8'hA4) begin
         err++; $display("FAIL wrap_last got %h/%h want ef/a4", wr_addr[255], wr_data[255]);
      end
      bad = 0;
      for (int i = 0; i < 256; i++) begin
         if (oam_mem[8'(8'hF0 + 8'(i))] !== ram_val(16'h0300 + 16'(i))) bad++;
      end
      chk++; if (bad !== 0) begin err++; $display("FAIL wrap_oam bad_bytes got %0d want 0", bad); end
   endtask

   task automatic test_ce_third;
      bit ok;
      int bad;
      ce_mode = 1;
      start_dma(8'h02, 8'h00);
      wait_done(6000, ok);
      chk++; if (ok !== 1'b1) begin err++; $display("FAIL ce3_timeout got %b want 1", ok); end
      chk++; if (write_cnt !== 256) begin err++; $display("FAIL ce3_writes got %0d want 256", write_cnt); end
      chk++; if (ce_bad !== 0) begin err++; $display("FAIL ce3_strobe_off_ce got %0d want 0", ce_bad); end
      chk++; if (halt_ce !== 513) begin err++; $display("FAIL ce3_halt_cycles got %0d want 513", halt_ce); end
      chk++; if (halt_clks !== 1539) begin err++; $display("FAIL ce3_halt_clks got %0d want 1539", halt_clks); end
      chk++; if (done_cnt !== 1) begin err++; $display("FAIL ce3_done got %0d want 1", done_cnt); end
      bad = 0;
      for (int i = 0; i < 256; i++) if (oam_mem[i] !== (8'(i) ^ 8'h5A)) bad++;
      chk++; if (bad !== 0) begin err++; $display("FAIL ce3_oam bad_bytes got %0d want 0", bad); end
      ce_mode = 0;
      repeat (3) @(posedge clk);
   endtask

   task automatic test_second_we;
      bit ok;
      int bad;
      start_dma(8'h02, 8'h00);
      wait_writes(100, ok);
      #2;
      reg_data = 8'h07;
      reg_we   = 1'b1;
      @(posedge clk);
      #2;
      reg_we = 1'b0;
      wait_done(3000, ok);
      chk++; if (ok !== 1'b1) begin err++; $display("FAIL we2_timeout got %b want 1", ok); end
      chk++; if (write_cnt !== 256 || halt_clks !== 513) begin
         err++; $display("FAIL we2_len got writes=%0d halt=%0d want 256/513", write_cnt, halt_clks);
      end
      bad = 0;
      for (int i = 0; i < 256; i++) if (oam_mem[i] !== (8'(i) ^ 8'h5A)) bad++;
      chk++; if (bad !== 0) begin err++; $display("FAIL we2_oam bad_bytes got %0d want 0", bad); end
   endtask

   task automatic test_reset_mid;
      bit ok;
      int bad;
      start_dma(8'h02, 8'h00);
      wait_writes(40, ok);
      #2;
      reset_n = 1'b0;
      #1;
      chk++; if ({cpu_halt, mem_rd, mem_addr, oam_dma, oam_addr, oam_data, dma_done} !== 35'h0) begin
         err++; $display("FAIL rstmid_outputs got halt=%b rd=%b addr=%h dma=%b oaddr=%h odata=%h done=%b want all 0",
                         cpu_halt, mem_rd, mem_addr, oam_dma, oam_addr, oam_data, dma_done);
      end
      repeat (5) @(posedge clk);
      chk++; if (write_cnt !== 40 || done_cnt !== 0) begin
         err++; $display("FAIL rstmid_stop got writes=%0d done=%0d want 40/0", write_cnt, done_cnt);
      end
      bad = 0;
      for (int i = 0; i < 256; i++) begin
         if (oam_mem[i] !== ((i < 40) ? (8'(i) ^ 8'h5A) : 8'hEE)) bad++;
      end
      chk++; if (bad !== 0) begin err++; $display("FAIL rstmid_oam bad_bytes got %0d want 0", bad); end
      #2;
      reset_n = 1'b1;
      start_dma(8'h02, 8'h00);
      wait_done(3000, ok);
      chk++; if (ok !== 1'b1 || write_cnt !== 256) begin
         err++; $display("FAIL rstmid_restart got ok=%b writes=%0d want 1/256", ok, write_cnt);
      end
      chk++; if (wr_addr[0] !== 8'h00 || wr_data[0] !== 8'h5A) begin
         err++; $display("FAIL rstmid_first got %h/%h want 00/5a", wr_addr[0], wr_data[0]);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_odd();
      test_wrap();
      test_ce_third();
      test_second_we();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", err, chk);
      $finish;
   end

endmodule
